// File: rtl/tva_pkg.sv
// Shared types for the attention token-precision path:
// precision codes and the selector FSM states.
package tva_pkg;

  typedef enum logic [3:0] {
    PREC_INT4 = 4'd0,
    PREC_INT8 = 4'd1,
    PREC_FP16 = 4'd2
  } prec_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACCUM,
    ST_CLASSIFY,
    ST_DONE
  } tps_state_t;

endpackage

// File: rtl/token_precision_selector_if.sv
// Start/done bundle for token_precision_selector: matrix,
// thresholds in; per-token codes and completion flags out.
interface token_precision_selector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(L*N) + 1
);

  logic                         start;
  logic [DATA_WIDTH*L*N*L-1:0]  A_in;
  logic [ACC_WIDTH-1:0]         thr_low;
  logic [ACC_WIDTH-1:0]         thr_high;
  logic [3:0]                   token_precision [L-1:0];
  logic                         done;
  logic                         out_valid;

  modport master (
    output start,
    output A_in,
    output thr_low,
    output thr_high,
    input  token_precision,
    input  done,
    input  out_valid
  );

  modport slave (
    input  start,
    input  A_in,
    input  thr_low,
    input  thr_high,
    output token_precision,
    output done,
    output out_valid
  );

endinterface

// File: rtl/token_prec_classify.sv
// Maps one column sum onto a precision code using the
// two thresholds; the high threshold always wins.
module token_prec_classify
  import tva_pkg::*;
#(
  parameter int ACC_WIDTH = 20
) (
  input  logic [ACC_WIDTH-1:0] sum_i,
  input  logic [ACC_WIDTH-1:0] thr_low_i,
  input  logic [ACC_WIDTH-1:0] thr_high_i,
  output prec_code_t           code_o
);

  logic ge_hi;
  logic ge_lo;

  assign ge_hi = (sum_i >= thr_high_i);
  assign ge_lo = (sum_i >= thr_low_i);

  // Terms are made exclusive so the decoder stays unique
  always_comb begin
    code_o = PREC_INT4;
    unique case (1'b1)
      ge_hi:            code_o = PREC_FP16;
      (!ge_hi && ge_lo): code_o = PREC_INT8;
      default:          code_o = PREC_INT4;
    endcase
  end

endmodule

// File: rtl/token_precision_selector.sv
// Column-sums the attention matrix one query row per cycle
// and registers a precision code for every key/value token.
module token_precision_selector
  import tva_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(L*N) + 1
) (
  input logic                      clk,
  input logic                      rst_n,
  token_precision_selector_if.slave bus
);

  localparam int E  = L * N * L;
  localparam int IW = (E > 1) ? $clog2(E) : 1;
  localparam int RW = (L > 1) ? $clog2(L) : 1;

  tps_state_t state_q, state_d;

  logic [E-1:0][DATA_WIDTH-1:0] a_q;
  logic [ACC_WIDTH-1:0]         lo_q;
  logic [ACC_WIDTH-1:0]         hi_q;
  logic [ACC_WIDTH-1:0]         sum_q [L];
  logic [ACC_WIDTH-1:0]         sum_d [L];
  logic [RW-1:0]                row_q;
  logic                         row_last;
  logic                         done_q, done_d;
  logic                         valid_q, valid_d;
  logic [3:0]                   prec_q [L];
  prec_code_t                   code_w [L];

  assign row_last = (row_q == RW'(L-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (bus.start) state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_ACCUM;
      ST_ACCUM:    if (row_last) state_d = ST_CLASSIFY;
      ST_CLASSIFY: state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // out_valid drops when a new pass is accepted, rises with done
  always_comb begin
    done_d  = (state_d == ST_DONE);
    valid_d = valid_q;
    if (state_q == ST_IDLE && bus.start) begin
      valid_d = 1'b0;
    end else if (state_d == ST_DONE) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    for (int j = 0; j < L; j++) begin
      sum_d[j] = sum_q[j];
      for (int n = 0; n < N; n++) begin
        sum_d[j] = sum_d[j] + ACC_WIDTH'(
          a_q[IW'(int'(row_q) * N * L + n * L + j)]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      row_q <= '0;
      for (int j = 0; j < L; j++) begin
        sum_q[j]  <= '0;
        prec_q[j] <= PREC_FP16;
      end
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          a_q   <= bus.A_in;
          lo_q  <= bus.thr_low;
          hi_q  <= bus.thr_high;
          row_q <= '0;
          for (int j = 0; j < L; j++) begin
            sum_q[j] <= '0;
          end
        end
        ST_ACCUM: begin
          row_q <= row_q + RW'(1);
          for (int j = 0; j < L; j++) begin
            sum_q[j] <= sum_d[j];
          end
        end
        ST_CLASSIFY: begin
          for (int j = 0; j < L; j++) begin
            prec_q[j] <= code_w[j];
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_cls
    token_prec_classify #(
      .ACC_WIDTH (ACC_WIDTH)
    ) u_cls (
      .sum_i      (sum_q[g]),
      .thr_low_i  (lo_q),
      .thr_high_i (hi_q),
      .code_o     (code_w[g])
    );
    assign bus.token_precision[g] = prec_q[g];
  end

  assign bus.done      = done_q;
  assign bus.out_valid = valid_q;

endmodule
